mac_array_ctrl: RTL
===================

# mac_array_ctrl

Sequencer for the row x col systolic array of `mac_tile` instances. It accepts a job (kernel load followed by N activation vectors), and drives the per-row 2-bit instruction buses with the row-to-row diagonal skew. It also drives the L0 activation/weight buffer read strobe and reports busy/done to the top-level core controller. It sits between the core FSM and the array's west edge.

## Interface
- `row`, 8, number of array rows (one `inst_w` pair per row)
- `col`, 8, number of array columns (kernel load length in cycles)
- `cnt_bw`, 8, width of the activation-count input and internal counters
- `clk`  input  1  clock, all logic on rising edge
- `reset`  input  1  synchronous, active-high; one clock, synchronous reset, active-high
- `start`  input  1  job request pulse; honoured only in IDLE
- `n_act`  input  cnt_bw  activation vectors in this job; sampled with accepted `start`
- `l0_rd`  output  1  L0 read strobe; L0 returns data one cycle later
- `inst_w`  output  2*row  row r instruction at bits [2r+1:2r]; bit1 execute, bit0 kernel load
- `busy`  output  1  high from the cycle after accepted start through DONE inclusive
- `done`  output  1  one-cycle pulse at job end

## Operation
- FSM states: IDLE, LOAD, GAP, EXEC, DRAIN, DONE.
- IDLE: `start`=1 latches `n_act` and moves to LOAD. `start` is ignored in every other state, with no queuing.
- LOAD: `col` cycles. Base instruction is 2'b01.
- GAP: 1 cycle. Base instruction is 2'b00. It separates the last weight from the first activation.
- EXEC: `n_act` cycles. Base instruction is 2'b10. If latched `n_act`=0, GAP goes directly to DRAIN.
- DRAIN: row+col+1 cycles. Base instruction is 2'b00. This flushes the skew pipeline and lets the last psum exit the south edge.
- DONE: 1 cycle with `done`=1, then IDLE.
- `l0_rd` = 1 exactly in LOAD and EXEC. It is decoded from the state register and is glitch-free.
- Row r instruction = base instruction delayed by r+1 registers. The +1 aligns with the L0 read latency, and the r term gives the diagonal skew.
- inst value 2'b11 is never generated.
- Counters are `cnt_bw` bits. Phase counters reload on state entry and count down to 1. Widths must hold max(col, n_act, row+col+1) without wrap.
- Reset while in any state:
  - state goes to IDLE and all counters clear;
  - every skew register clears, so `inst_w`=0 on the next cycle;
  - `busy`, `done`, `l0_rd` all go to 0.
- Reset values: `inst_w`=0, `l0_rd`=0, `busy`=0, `done`=0.

## Timing
- Call the edge that samples an accepted `start` edge 0. Cycle k is the interval after edge k.
- LOAD occupies cycles 1..col.
- GAP is cycle col+1.
- EXEC occupies cycles col+2..col+1+n_act.
- DRAIN occupies the next row+col+1 cycles.
- `done` is high in cycle 2*col+row+n_act+3.
- The first cycle after DONE is IDLE. A `start` sampled in the DONE cycle is ignored. A `start` in the following cycle is accepted, so back-to-back jobs have a minimum of one idle cycle between `done` and the next LOAD.
- Row r sees its first 2'b01 in cycle r+2, and its last 2'b10 in cycle col+2+n_act+r.
- All of row r's instructions land within DRAIN. The skew line is empty by DONE.

## Structure
- Shared package `mac_array_pkg`:
  - state encoding (enum of the six states);
  - instruction constants INST_IDLE=2'b00, INST_LOAD=2'b01, INST_EXEC=2'b10;
  - bit indices for execute/load.
- One sub-module, `inst_skew`. It is a parameterised delay line (row stages, 2 bits wide, synchronous reset to 0) whose stage r+1 output feeds row r. It is instantiated once.
- The FSM, counters and output decode live in `mac_array_ctrl`.

## Test plan
- Nominal, row=col=8, n_act=16:
  - `l0_rd` high in cycles 1-8 and 10-25;
  - row0 `inst_w`=01 in cycles 2-9 and 10 in cycles 11-26;
  - row7 shifted +7;
  - `done` in cycle 43;
  - `busy` high in cycles 1-43.
- n_act=0: no 2'b10 on any row, DRAIN starts in cycle 10, `done` in cycle 27.
- `start` pulsed in cycles 5, 20 and the DONE cycle of a job: all are ignored. `start` in the cycle after `done` is accepted, and its LOAD begins one cycle later.
- Reset asserted in EXEC cycle 15 of the nominal job:
  - from cycle 16, `inst_w`=0, `l0_rd`=0, `busy`=0;
  - no `done` pulse;
  - a new start afterwards reproduces the nominal timeline exactly.
- n_act=255 (cnt_bw max), row=col=8: the EXEC length is exactly 255 cycles with no counter wrap, and `done` arrives in cycle 282.
- Every cycle over random jobs:
  - no row ever carries 2'b11;
  - the row r+1 sequence equals the row r sequence delayed by one cycle.

Source files
------------

// File: rtl/mac_array_pkg.sv
// Shared definitions for the MAC array sequencer: FSM state encoding,
// per-row instruction codes and the bit positions inside an instruction.
package mac_array_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_GAP   = 3'd2,
        S_EXEC  = 3'd3,
        S_DRAIN = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    localparam logic [1:0] INST_IDLE = 2'b00;
    localparam logic [1:0] INST_LOAD = 2'b01;
    localparam logic [1:0] INST_EXEC = 2'b10;

    localparam int EXEC_BIT = 1;
    localparam int LOAD_BIT = 0;

    // Base (row 0, undelayed) instruction for a given phase. 2'b11 is
    // unreachable because only LOAD and EXEC set a bit, and never together.
    function automatic logic [1:0] base_inst(input state_t s);
        logic [1:0] inst;
        inst = INST_IDLE;
        case (s)
            S_LOAD:  inst = INST_LOAD;
            S_EXEC:  inst = INST_EXEC;
            default: inst = INST_IDLE;
        endcase
        return inst;
    endfunction

endpackage

// File: rtl/mac_array_ctrl_inst_skew.sv
// Diagonal skew line for the array's west edge. Stage 0 is one register
// behind the base instruction (matching L0 read latency) and feeds row 0;
// each further stage adds one cycle and feeds the next row.
module inst_skew
    import mac_array_pkg::*;
#(
    parameter int stages = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [1:0]            din,
    output logic [2*stages-1:0]   taps
);

    logic [1:0] pipe [stages];

    // Shift the base instruction down the rows; reset empties the whole line.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < stages; i++) begin
                pipe[i] <= INST_IDLE;
            end
        end else begin
            pipe[0] <= din;
            for (int i = 1; i < stages; i++) begin
                pipe[i] <= pipe[i-1];
            end
        end
    end

    genvar g;
    generate
        for (g = 0; g < stages; g++) begin : g_tap
            assign taps[2*g +: 2] = pipe[g];
        end
    endgenerate

endmodule

// File: rtl/mac_array_ctrl.sv
// Job sequencer for the systolic MAC array: kernel load, a one-cycle gap,
// activation execution and a drain long enough to empty the skew line and
// let the last partial sum leave the south edge. Outputs are registered.
//
// Handshake: start is a single-cycle request with no ready; it is accepted
// only when the FSM is in IDLE (n_act captured on that same edge) and is
// silently dropped in every other state. done is a one-cycle pulse and busy
// covers LOAD through DONE inclusive.
module mac_array_ctrl
    import mac_array_pkg::*;
#(
    parameter int row    = 8,
    parameter int col    = 8,
    parameter int cnt_bw = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [cnt_bw-1:0]    n_act,
    output logic                 l0_rd,
    output logic [2*row-1:0]     inst_w,
    output logic                 busy,
    output logic                 done,
    output state_t               fsm_state
);

    localparam logic [cnt_bw-1:0] LOAD_LEN  = cnt_bw'(col);
    localparam logic [cnt_bw-1:0] DRAIN_LEN = cnt_bw'(row + col + 1);
    localparam logic [cnt_bw-1:0] CNT_LAST  = cnt_bw'(1);

    state_t            state;
    logic [cnt_bw-1:0] cnt;
    logic [cnt_bw-1:0] n_act_q;
    logic [1:0]        base;

    assign fsm_state = state;
    assign base      = base_inst(state);

    // Phase sequencing: counters reload on entry to a timed phase and count
    // down to 1; l0_rd/busy/done are set on the transition into each state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= S_IDLE;
            cnt     <= '0;
            n_act_q <= '0;
            l0_rd   <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state   <= S_LOAD;
                        n_act_q <= n_act;
                        cnt     <= LOAD_LEN;
                        l0_rd   <= 1'b1;
                        busy    <= 1'b1;
                    end
                end
                S_LOAD: begin
                    if (cnt == CNT_LAST) begin
                        state <= S_GAP;
                        cnt   <= '0;
                        l0_rd <= 1'b0;
                    end else begin
                        cnt <= cnt - CNT_LAST;
                    end
                end
                S_GAP: begin
                    if (n_act_q == '0) begin
                        state <= S_DRAIN;
                        cnt   <= DRAIN_LEN;
                    end else begin
                        state <= S_EXEC;
                        cnt   <= n_act_q;
                        l0_rd <= 1'b1;
                    end
                end
                S_EXEC: begin
                    if (cnt == CNT_LAST) begin
                        state <= S_DRAIN;
                        cnt   <= DRAIN_LEN;
                        l0_rd <= 1'b0;
                    end else begin
                        cnt <= cnt - CNT_LAST;
                    end
                end
                S_DRAIN: begin
                    if (cnt == CNT_LAST) begin
                        state <= S_DONE;
                        cnt   <= '0;
                        done  <= 1'b1;
                    end else begin
                        cnt <= cnt - CNT_LAST;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= S_IDLE;
                    cnt   <= '0;
                    l0_rd <= 1'b0;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

    inst_skew #(
        .stages (row)
    ) u_inst_skew (
        .clk   (clk),
        .reset (reset),
        .din   (base),
        .taps  (inst_w)
    );

endmodule
